// File: rtl/psram_arbiter.sv
// psram_arbiter
//   Two-port arbiter placing CPU (DCJ11 bus) and DMA accesses onto a single
//   PSRAM controller command port, one access outstanding at a time.
//   CPU has priority; DMA wins when the CPU is idle or after STARVE_LIMIT
//   back-to-back CPU grants made while DMA was waiting.
//
// Parameters
//   STARVE_LIMIT : CPU grants with DMA pending before DMA is forced through
//   TIMEOUT      : WAIT cycles allowed for ram_done before the access aborts
//
// Ports
//   clk_x2, rstb                 : clock (posedge), synchronous active-low reset
//   cpu_req/we/byte/addr/wdata   : CPU request (level, held until cpu_ack)
//   cpu_ack/rdata/err            : CPU completion pulse, read data, timeout flag
//   dma_*                        : DMA requester, same semantics as CPU
//   ram_read/write/byte/addr/wdata : one-cycle command to the RAM controller
//   ram_rdata, ram_busy, ram_done  : controller read data, back-pressure, done
module psram_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk_x2,
  input  logic        rstb,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_byte,
  input  logic [21:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [15:0] cpu_rdata,
  output logic        cpu_err,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic        dma_byte,
  input  logic [21:0] dma_addr,
  input  logic [15:0] dma_wdata,
  output logic        dma_ack,
  output logic [15:0] dma_rdata,
  output logic        dma_err,
  output logic        ram_read,
  output logic        ram_write,
  output logic        ram_byte,
  output logic [21:0] ram_addr,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata,
  input  logic        ram_busy,
  input  logic        ram_done
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state, state_nxt;
  logic          owner_dma;
  logic          lat_we;
  logic          lat_byte;
  logic [21:0]   lat_addr;
  logic [15:0]   lat_wdata;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          err_q;

  logic grant_any;
  logic grant_dma;
  logic cmd_fire;
  logic tmo_hit;

  assign grant_any = cpu_req | dma_req;
  // DMA takes the slot when the CPU is not asking or has been favoured too long.
  assign grant_dma = dma_req & (~cpu_req | (starve_cnt >= SW'(STARVE_LIMIT)));
  assign cmd_fire  = (state == ISSUE) & ~ram_busy;
  // Last permitted WAIT cycle with no completion: abort on this edge.
  assign tmo_hit   = (state == WAIT) & ~ram_done & (tmo_cnt == TW'(TIMEOUT - 1));

  // The latched request drives the controller bus; it only matters while the
  // strobe is up, but holding it steady keeps the bus quiet between accesses.
  assign ram_addr  = lat_addr;
  assign ram_wdata = lat_wdata;

  always_comb begin
    state_nxt = state;
    ram_read  = 1'b0;
    ram_write = 1'b0;
    ram_byte  = 1'b0;
    cpu_ack   = 1'b0;
    dma_ack   = 1'b0;
    cpu_err   = 1'b0;
    dma_err   = 1'b0;
    case (state)
      IDLE: begin
        if (grant_any) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (cmd_fire) begin
          ram_read  = ~lat_we;
          ram_write = lat_we;
          ram_byte  = lat_we & lat_byte;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (ram_done || tmo_hit) state_nxt = DONE;
      end
      DONE: begin
        cpu_ack   = ~owner_dma;
        dma_ack   = owner_dma;
        cpu_err   = ~owner_dma & err_q;
        dma_err   = owner_dma & err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_x2) begin
    if (!rstb) begin
      state      <= IDLE;
      owner_dma  <= 1'b0;
      lat_we     <= 1'b0;
      lat_byte   <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      starve_cnt <= '0;
      tmo_cnt    <= '0;
      err_q      <= 1'b0;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (grant_any) begin
            owner_dma <= grant_dma;
            lat_we    <= grant_dma ? dma_we    : cpu_we;
            lat_byte  <= grant_dma ? dma_byte  : cpu_byte;
            lat_addr  <= grant_dma ? dma_addr  : cpu_addr;
            lat_wdata <= grant_dma ? dma_wdata : cpu_wdata;
            err_q     <= 1'b0;
          end
          // Any DMA grant, or DMA no longer waiting, forgives the CPU's history.
          if (grant_dma || !dma_req) begin
            starve_cnt <= '0;
          end else if (cpu_req && (starve_cnt < SW'(STARVE_LIMIT))) begin
            starve_cnt <= starve_cnt + SW'(1);
          end
        end
        ISSUE: begin
          tmo_cnt <= '0;
        end
        WAIT: begin
          tmo_cnt <= tmo_cnt + TW'(1);
          if (ram_done) begin
            if (!lat_we) begin
              if (owner_dma) dma_rdata <= ram_rdata;
              else           cpu_rdata <= ram_rdata;
            end
          end else if (tmo_hit) begin
            err_q <= 1'b1;
            if (owner_dma) dma_rdata <= 16'hFFFF;
            else           cpu_rdata <= 16'hFFFF;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_psram_arbiter.sv
// tb_psram_arbiter
//   Directed bench for psram_arbiter: reset values, CPU read/write latency,
//   byte write under controller back-pressure, timeout, starvation ordering,
//   stray ram_done, and reset in the middle of an access.
module tb_psram_arbiter;

  logic        clk_x2 = 1'b0;
  logic        rstb;
  logic        cpu_req, cpu_we, cpu_byte;
  logic [21:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ack, cpu_err;
  logic [15:0] cpu_rdata;
  logic        dma_req, dma_we, dma_byte;
  logic [21:0] dma_addr;
  logic [15:0] dma_wdata;
  logic        dma_ack, dma_err;
  logic [15:0] dma_rdata;
  logic        ram_read, ram_write, ram_byte;
  logic [21:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic        ram_busy, ram_done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc_cnt  = 0;

  // Results of the most recent access
  int          r_start, r_cmd, r_ack, r_ncmd;
  logic        r_wr, r_byte, r_err;
  logic [21:0] r_addr;
  logic [15:0] r_wdata, r_rdata;
  logic [1:0]  r_port;

  psram_arbiter #(.STARVE_LIMIT(8), .TIMEOUT(255)) dut (
    .clk_x2(clk_x2), .rstb(rstb),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_byte(cpu_byte), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .dma_req(dma_req), .dma_we(dma_we), .dma_byte(dma_byte), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_ack(dma_ack), .dma_rdata(dma_rdata), .dma_err(dma_err),
    .ram_read(ram_read), .ram_write(ram_write), .ram_byte(ram_byte), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_busy(ram_busy), .ram_done(ram_done)
  );

  always #5 clk_x2 = ~clk_x2;
  always @(posedge clk_x2) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cpu_ack"},   cpu_ack,   0);
    check({tag, "_dma_ack"},   dma_ack,   0);
    check({tag, "_cpu_err"},   cpu_err,   0);
    check({tag, "_dma_err"},   dma_err,   0);
    check({tag, "_ram_read"},  ram_read,  0);
    check({tag, "_ram_write"}, ram_write, 0);
    check({tag, "_ram_byte"},  ram_byte,  0);
    check({tag, "_ram_addr"},  ram_addr,  0);
    check({tag, "_ram_wdata"}, ram_wdata, 0);
    check({tag, "_cpu_rdata"}, cpu_rdata, 0);
    check({tag, "_dma_rdata"}, dma_rdata, 0);
  endtask

  // Plays the RAM controller for one access. The first negedge seen is the
  // arbitration cycle. busy_cyc: cycles ram_busy stays high from that cycle;
  // done_dly: cycles after the command that ram_done pulses (0 = never).
  task automatic run_access(input int busy_cyc, input int done_dly, input logic [15:0] rd);
    r_cmd = -1; r_ack = -1; r_ncmd = 0; r_port = 2'b00;
    r_wr = 1'b0; r_byte = 1'b0; r_addr = '0; r_wdata = '0; r_rdata = '0; r_err = 1'b0;
    ram_busy = (busy_cyc > 0);
    for (int i = 0; i < 40 && r_cmd < 0; i++) begin
      @(negedge clk_x2);
      if (i == 0) r_start = cyc_cnt;
      if (ram_read || ram_write) begin
        r_cmd = cyc_cnt; r_ncmd++;
        r_wr = ram_write; r_addr = ram_addr; r_wdata = ram_wdata; r_byte = ram_byte;
      end
      @(posedge clk_x2); #1;
      if (i + 1 >= busy_cyc) ram_busy = 1'b0;
    end
    check("cmd_seen", (r_cmd >= 0), 1);
    if (done_dly > 0) begin
      for (int d = 1; d < done_dly; d++) begin @(posedge clk_x2); #1; end
      ram_done = 1'b1; ram_rdata = rd;
      @(posedge clk_x2); #1;
      ram_done = 1'b0; ram_rdata = 16'h5A5A;
    end
    for (int i = 0; i < 300 && r_ack < 0; i++) begin
      @(negedge clk_x2);
      if (ram_read || ram_write) r_ncmd++;
      if (cpu_ack || dma_ack) begin
        r_ack   = cyc_cnt;
        r_port  = {cpu_ack, dma_ack};
        r_rdata = cpu_ack ? cpu_rdata : dma_rdata;
        r_err   = cpu_ack ? cpu_err : dma_err;
      end else begin
        @(posedge clk_x2); #1;
      end
    end
    check("ack_seen", (r_ack >= 0), 1);
    check("single_cmd", r_ncmd, 1);
  endtask

  initial begin
    rstb = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_byte = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_byte = 0; dma_addr = '0; dma_wdata = '0;
    ram_rdata = 16'h5A5A; ram_busy = 0; ram_done = 0;

    // Reset state
    repeat (3) @(posedge clk_x2);
    @(negedge clk_x2);
    check_reset_outputs("reset");
    @(posedge clk_x2); #1;
    rstb = 1'b1;
    @(posedge clk_x2); #1;

    // CPU read, done two cycles after the command; byte flag must not leak on reads
    cpu_req = 1; cpu_we = 0; cpu_byte = 1; cpu_addr = 22'o0001000;
    run_access(0, 2, 16'o012737);
    cpu_req = 0; cpu_byte = 0;
    check("rd_cmd_lat",   r_cmd - r_start, 1);
    check("rd_is_read",   r_wr, 0);
    check("rd_addr",      r_addr, 22'o0001000);
    check("rd_byte_zero", r_byte, 0);
    check("rd_ack_lat",   r_ack - r_cmd, 3);
    check("rd_port",      r_port, 2'b10);
    check("rd_rdata",     r_rdata, 16'o012737);
    check("rd_err",       r_err, 0);
    @(posedge clk_x2); #1;

    // CPU word write at minimum latency; read data holds across a write
    cpu_req = 1; cpu_we = 1; cpu_byte = 0; cpu_addr = 22'o7654321; cpu_wdata = 16'hBEEF;
    run_access(0, 1, 16'h1111);
    cpu_req = 0; cpu_we = 0;
    check("wr_req_to_ack", r_ack - r_start, 3);
    check("wr_is_write",   r_wr, 1);
    check("wr_byte",       r_byte, 0);
    check("wr_addr",       r_addr, 22'o7654321);
    check("wr_wdata",      r_wdata, 16'hBEEF);
    check("wr_rdata_hold", r_rdata, 16'o012737);
    @(posedge clk_x2); #1;

    // DMA byte write behind 3 busy cycles; requester changes everything after the grant
    dma_req = 1; dma_we = 1; dma_byte = 1; dma_addr = 22'o17757776; dma_wdata = 16'h00A5;
    fork
      run_access(3, 1, 16'h2222);
      begin
        @(posedge clk_x2); #2;
        dma_req = 0; dma_we = 0; dma_byte = 0; dma_addr = '0; dma_wdata = 16'hFFFF;
      end
    join
    check("dbw_cmd_lat", r_cmd - r_start, 3);
    check("dbw_write",   r_wr, 1);
    check("dbw_byte",    r_byte, 1);
    check("dbw_addr",    r_addr, 22'o17757776);
    check("dbw_wdata",   r_wdata, 16'h00A5);
    check("dbw_port",    r_port, 2'b01);
    check("dbw_err",     r_err, 0);
    check("dbw_rdata",   r_rdata, 16'h0000);
    @(posedge clk_x2); #1;

    // CPU read with no ram_done: timeout after 255 WAIT cycles
    cpu_req = 1; cpu_we = 0; cpu_addr = 22'o0000100;
    run_access(0, 0, 16'h0);
    cpu_req = 0;
    check("tmo_ack_lat", r_ack - r_cmd, 256);
    check("tmo_port",    r_port, 2'b10);
    check("tmo_err",     r_err, 1);
    check("tmo_rdata",   r_rdata, 16'hFFFF);
    @(negedge clk_x2);
    check("tmo_err_clear", cpu_err, 0);
    check("tmo_rdata_hold", cpu_rdata, 16'hFFFF);
    @(posedge clk_x2); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 22'o0000102;
    run_access(0, 1, 16'h1234);
    cpu_req = 0;
    check("post_tmo_err",   r_err, 0);
    check("post_tmo_rdata", r_rdata, 16'h1234);
    @(posedge clk_x2); #1;

    // Stray ram_done while idle is ignored
    ram_done = 1; ram_rdata = 16'hDEAD;
    @(posedge clk_x2); #1;
    ram_done = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_x2);
      check("stray_done_noack", {cpu_ack, dma_ack, ram_read, ram_write}, 4'b0000);
      check("stray_done_rdata", cpu_rdata, 16'h1234);
    end
    @(posedge clk_x2); #1;

    // Both requesters held: 8 CPU grants then 1 DMA, repeating
    cpu_req = 1; cpu_we = 0; cpu_addr = 22'o0000200;
    dma_req = 1; dma_we = 0; dma_addr = 22'o0000300;
    for (int k = 0; k < 18; k++) begin
      run_access(0, 1, 16'h1000 + 16'(k));
      check("starve_port",  r_port, (k % 9 == 8) ? 2'b01 : 2'b10);
      check("starve_addr",  r_addr, (k % 9 == 8) ? 22'o0000300 : 22'o0000200);
      check("starve_rdata", r_rdata, 16'h1000 + 16'(k));
    end
    cpu_req = 0; dma_req = 0;
    @(posedge clk_x2); #1;

    // Reset during WAIT of a DMA read, with a CPU request pending
    dma_req = 1; dma_we = 0; dma_addr = 22'o0000400;
    @(posedge clk_x2); #1;
    @(negedge clk_x2);
    check("rst_dma_cmd", ram_read, 1);
    @(posedge clk_x2); #1;
    rstb = 0; dma_req = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 22'o0000500;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk_x2); #1;
      ram_done = (i == 0);
      @(negedge clk_x2);
      check_reset_outputs("midrst");
    end
    @(posedge clk_x2); #1;
    ram_done = 0;
    rstb = 1;
    run_access(0, 1, 16'h4321);
    cpu_req = 0;
    check("rst_first_grant", r_cmd - r_start, 1);
    check("rst_cpu_addr",    r_addr, 22'o0000500);
    check("rst_port",        r_port, 2'b10);
    check("rst_rdata",       r_rdata, 16'h4321);
    @(posedge clk_x2); #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
